// File: rtl/ex_stage_if.sv
// ex_stage_if: operand/control bundle into the execute stage and its write-back results out
//   master: decode/ID-EX side; drives operands and control, observes results
//   slave : ex_stage; consumes operands and control, drives results
//   inputs : aluop_i[8], alusel_i[3], reg1_i/reg2_i[32], wd_i[5], wreg_i, flush_i
//   outputs: wd_o[5], wreg_o, wdata_o[32], whilo_o, hi_o/lo_o[32], stallreq_o
interface ex_stage_if;
    logic [7:0]  aluop_i;
    logic [2:0]  alusel_i;
    logic [31:0] reg1_i;
    logic [31:0] reg2_i;
    logic [4:0]  wd_i;
    logic        wreg_i;
    logic        flush_i;
    logic [4:0]  wd_o;
    logic        wreg_o;
    logic [31:0] wdata_o;
    logic        whilo_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;
    logic        stallreq_o;
    modport master (
        output aluop_i, alusel_i, reg1_i, reg2_i, wd_i, wreg_i, flush_i,
        input  wd_o, wreg_o, wdata_o, whilo_o, hi_o, lo_o, stallreq_o
    );
    modport slave (
        input  aluop_i, alusel_i, reg1_i, reg2_i, wd_i, wreg_i, flush_i,
        output wd_o, wreg_o, wdata_o, whilo_o, hi_o, lo_o, stallreq_o
    );
endinterface

// File: rtl/ex_stage.sv
// ex_stage: MIPS-style execute stage with logic/shift/arith ALU and optional multi-cycle divider
//   clk : rising-edge clock
//   rst : synchronous active-high reset; forces every output to zero while high
//   bus : ex_stage_if.slave -- operands/control in, GPR and HI/LO write-back plus stall request out
//   Macro EX_DIVIDER_EN builds the DIV/DIVU FSM (33-cycle restoring divider); without it
//   DIV/DIVU behave as NOP and stallreq_o/whilo_o/hi_o/lo_o are tied to zero.
module ex_stage (
    input logic clk,
    input logic rst,
    ex_stage_if.slave bus
);
    localparam logic [7:0] OP_AND  = 8'b0010_0100;
    localparam logic [7:0] OP_OR   = 8'b0010_0101;
    localparam logic [7:0] OP_XOR  = 8'b0010_0110;
    localparam logic [7:0] OP_NOR  = 8'b0010_0111;
    localparam logic [7:0] OP_SLL  = 8'b0111_1100;
    localparam logic [7:0] OP_SRL  = 8'b0000_0010;
    localparam logic [7:0] OP_SRA  = 8'b0000_0011;
    localparam logic [7:0] OP_SLT  = 8'b0010_1010;
    localparam logic [7:0] OP_SLTU = 8'b0010_1011;
    localparam logic [7:0] OP_ADDU = 8'b0010_0001;
    localparam logic [7:0] OP_SUBU = 8'b0010_0011;
    localparam logic [7:0] OP_DIV  = 8'b0001_1010;
    localparam logic [7:0] OP_DIVU = 8'b0001_1011;
    localparam logic [2:0] SEL_LOGIC = 3'b001;
    localparam logic [2:0] SEL_SHIFT = 3'b010;
    localparam logic [2:0] SEL_ARITH = 3'b100;
    logic [7:0]  op;
    logic [31:0] a, b, sra_res, logic_res, shift_res, arith_res, res;
    logic        is_div;
    assign op = bus.aluop_i;
    assign a = bus.reg1_i;
    assign b = bus.reg2_i;
    assign is_div = op == OP_DIV || op == OP_DIVU;
    // kept apart so the arithmetic shift is not demoted to logical by an unsigned mux context
    assign sra_res = $signed(b) >>> a[4:0];
    always_comb begin
        logic_res = op == OP_OR  ? a | b :
                    op == OP_AND ? a & b :
                    op == OP_XOR ? a ^ b :
                    op == OP_NOR ? ~(a | b) : '0;
        shift_res = op == OP_SLL ? b << a[4:0] :
                    op == OP_SRL ? b >> a[4:0] :
                    op == OP_SRA ? sra_res : '0;
        arith_res = op == OP_SLT  ? {31'b0, $signed(a) < $signed(b)} :
                    op == OP_SLTU ? {31'b0, a < b} :
                    op == OP_ADDU ? a + b :
                    op == OP_SUBU ? a - b : '0;
        res = bus.alusel_i == SEL_LOGIC ? logic_res :
              bus.alusel_i == SEL_SHIFT ? shift_res :
              bus.alusel_i == SEL_ARITH ? arith_res : '0;
    end
    assign bus.wd_o    = rst ? 5'd0 : bus.wd_i;
    assign bus.wreg_o  = !rst && bus.wreg_i && !is_div;
    assign bus.wdata_o = rst ? 32'd0 : res;
`ifdef EX_DIVIDER_EN
    localparam logic [1:0] IDLE       = 2'd0;
    localparam logic [1:0] DIV_ON     = 2'd1;
    localparam logic [1:0] DIV_BYZERO = 2'd2;
    localparam logic [1:0] DIV_END    = 2'd3;
    logic [1:0]  state;
    logic [4:0]  cnt;
    logic [31:0] dvd, dvs, rem;
    logic        neg_q, neg_r, is_divs, live;
    logic [32:0] r_sh, diff;
    assign is_divs = op == OP_DIV;
    assign live = !rst && !bus.flush_i;
    // dvd shifts left each step, absorbing quotient bits as the dividend bits leave;
    // diff[32] set means the trial subtraction borrowed, so the remainder is restored
    always_comb begin
        r_sh = {rem, dvd[31]};
        diff = r_sh - {1'b0, dvs};
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            dvd   <= '0;
            dvs   <= '0;
            rem   <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else if (bus.flush_i) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: if (is_div) begin
                    cnt   <= '0;
                    rem   <= '0;
                    neg_q <= is_divs && (a[31] ^ b[31]);
                    neg_r <= is_divs && a[31];
                    dvd   <= is_divs && a[31] ? -a : a;
                    dvs   <= is_divs && b[31] ? -b : b;
                    state <= b == 32'd0 ? DIV_BYZERO : DIV_ON;
                end
                DIV_ON: begin
                    dvd   <= {dvd[30:0], ~diff[32]};
                    rem   <= diff[32] ? r_sh[31:0] : diff[31:0];
                    cnt   <= cnt + 5'd1;
                    state <= cnt == 5'd31 ? DIV_END : DIV_ON;
                end
                DIV_BYZERO: begin
                    dvd   <= '0;
                    rem   <= '0;
                    neg_q <= 1'b0;
                    neg_r <= 1'b0;
                    state <= DIV_END;
                end
                default: state <= IDLE;
            endcase
        end
    end
    assign bus.stallreq_o = live && ((state == IDLE && is_div) || state == DIV_ON || state == DIV_BYZERO);
    assign bus.whilo_o = live && state == DIV_END;
    assign bus.lo_o = !bus.whilo_o ? 32'd0 : neg_q ? -dvd : dvd;
    assign bus.hi_o = !bus.whilo_o ? 32'd0 : neg_r ? -rem : rem;
`else
    assign bus.stallreq_o = 1'b0;
    assign bus.whilo_o = 1'b0;
    assign bus.lo_o = 32'd0;
    assign bus.hi_o = 32'd0;
`endif
    // a flushed cycle must never hold the pipeline or commit HI/LO
    flush_quiet: assert property (@(posedge clk) disable iff (rst)
        bus.flush_i |-> !bus.stallreq_o && !bus.whilo_o);
endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: scoreboard bench for ex_stage; driver queues expected outputs per cycle, monitor checks them
module tb_ex_stage;
    localparam logic [7:0] OP_NOP  = 8'h00;
    localparam logic [7:0] OP_AND  = 8'b0010_0100;
    localparam logic [7:0] OP_OR   = 8'b0010_0101;
    localparam logic [7:0] OP_XOR  = 8'b0010_0110;
    localparam logic [7:0] OP_NOR  = 8'b0010_0111;
    localparam logic [7:0] OP_SLL  = 8'b0111_1100;
    localparam logic [7:0] OP_SRL  = 8'b0000_0010;
    localparam logic [7:0] OP_SRA  = 8'b0000_0011;
    localparam logic [7:0] OP_SLT  = 8'b0010_1010;
    localparam logic [7:0] OP_SLTU = 8'b0010_1011;
    localparam logic [7:0] OP_ADDU = 8'b0010_0001;
    localparam logic [7:0] OP_SUBU = 8'b0010_0011;
    localparam logic [7:0] OP_DIV  = 8'b0001_1010;
    localparam logic [7:0] OP_DIVU = 8'b0001_1011;
    localparam logic [2:0] S_NOP   = 3'b000;
    localparam logic [2:0] S_LOGIC = 3'b001;
    localparam logic [2:0] S_SHIFT = 3'b010;
    localparam logic [2:0] S_ARITH = 3'b100;
    typedef struct {
        int          cyc;
        string       nm;
        logic [4:0]  wd;
        logic        wreg;
        logic [31:0] wdata;
        logic        whilo;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        stall;
    } exp_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int cyc = 0;
    int checks = 0;
    int passed = 0;
    exp_t q[$];
    exp_t m;
    ex_stage_if bus();
    ex_stage dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk)
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            m = q.pop_front();
            checks++;
            if ({bus.wd_o, bus.wreg_o, bus.wdata_o, bus.whilo_o, bus.hi_o, bus.lo_o, bus.stallreq_o} !==
                {m.wd, m.wreg, m.wdata, m.whilo, m.hi, m.lo, m.stall})
                $display("FAIL %s @cyc%0d: got wd=%0d wreg=%b wdata=%h whilo=%b hi=%h lo=%h stall=%b, want wd=%0d wreg=%b wdata=%h whilo=%b hi=%h lo=%h stall=%b",
                         m.nm, m.cyc, bus.wd_o, bus.wreg_o, bus.wdata_o, bus.whilo_o, bus.hi_o, bus.lo_o, bus.stallreq_o,
                         m.wd, m.wreg, m.wdata, m.whilo, m.hi, m.lo, m.stall);
            else
                passed++;
        end
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic drive(input logic [7:0] op, input logic [2:0] sel, input logic [31:0] r1, input logic [31:0] r2,
                         input logic [4:0] wd, input logic wreg, input logic fl);
        bus.aluop_i = op;
        bus.alusel_i = sel;
        bus.reg1_i = r1;
        bus.reg2_i = r2;
        bus.wd_i = wd;
        bus.wreg_i = wreg;
        bus.flush_i = fl;
    endtask
    task automatic want(input string nm, input logic [4:0] wd, input logic wreg, input logic [31:0] wdata,
                        input logic whilo, input logic [31:0] hi, input logic [31:0] lo, input logic stall);
        exp_t e;
        e.cyc = cyc;
        e.nm = nm;
        e.wd = wd;
        e.wreg = wreg;
        e.wdata = wdata;
        e.whilo = whilo;
        e.hi = hi;
        e.lo = lo;
        e.stall = stall;
        q.push_back(e);
    endtask
    task automatic vec(input string nm, input logic [7:0] op, input logic [2:0] sel,
                       input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] res);
        drive(op, sel, r1, r2, 5'd7, 1'b1, 1'b0);
        want(nm, 5'd7, 1'b1, res, 1'b0, 32'h0, 32'h0, 1'b0);
        tick();
    endtask
    task automatic nop_idle(input string nm);
        drive(OP_NOP, S_NOP, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
        want(nm, 5'd0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
        tick();
    endtask
    // DIV/DIVU held in EX while stalled; lat stall cycles then one result cycle
    task automatic run_div(input string nm, input logic [7:0] op, input logic [31:0] r1, input logic [31:0] r2,
                           input logic [31:0] hi, input logic [31:0] lo, input int lat, input logic fl_end);
        drive(op, S_NOP, r1, r2, 5'd3, 1'b1, 1'b0);
        for (int i = 0; i < lat; i++) begin
            want({nm, "_stall"}, 5'd3, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1);
            tick();
        end
        bus.flush_i = fl_end;
        want({nm, "_end"}, 5'd3, 1'b0, 32'h0, !fl_end, fl_end ? 32'h0 : hi, fl_end ? 32'h0 : lo, 1'b0);
        tick();
        nop_idle({nm, "_idle"});
    endtask
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1, "watchdog");
    end
    initial begin
        drive(OP_OR, S_LOGIC, 32'h0000_1100, 32'h0000_0011, 5'd1, 1'b1, 1'b0);
        tick();
        want("reset", 5'd0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
        tick();
        rst = 1'b0;
        want("ori", 5'd1, 1'b1, 32'h0000_1111, 1'b0, 32'h0, 32'h0, 1'b0);
        tick();
        vec("and",    OP_AND,  S_LOGIC, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200);
        vec("xor",    OP_XOR,  S_LOGIC, 32'hF0F0_1234, 32'h0FF0_FF00, 32'hFF00_ED34);
        vec("nor",    OP_NOR,  S_LOGIC, 32'h0000_1100, 32'h0000_0011, 32'hFFFF_EEEE);
        vec("sll",    OP_SLL,  S_SHIFT, 32'd4,         32'h0000_00FF, 32'h0000_0FF0);
        vec("srl",    OP_SRL,  S_SHIFT, 32'd8,         32'h8000_0000, 32'h0080_0000);
        vec("sra",    OP_SRA,  S_SHIFT, 32'd4,         32'h8000_0000, 32'hF800_0000);
        vec("sra_lo5",OP_SRA,  S_SHIFT, 32'h24,        32'h8000_0000, 32'hF800_0000);
        vec("slt",    OP_SLT,  S_ARITH, 32'hFFFF_FFFF, 32'd1,         32'h1);
        vec("sltu",   OP_SLTU, S_ARITH, 32'hFFFF_FFFF, 32'd1,         32'h0);
        vec("addu",   OP_ADDU, S_ARITH, 32'hFFFF_FFFF, 32'd2,         32'h1);
        vec("subu",   OP_SUBU, S_ARITH, 32'h0,         32'd1,         32'hFFFF_FFFF);
        vec("selnop", OP_OR,   S_NOP,   32'h1234_5678, 32'h1,         32'h0);
        vec("selunk", OP_OR,   3'b011,  32'h1234_5678, 32'h1,         32'h0);
`ifdef EX_DIVIDER_EN
        run_div("div_m7_2",  OP_DIV,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 33, 1'b0);
        run_div("div_7_m2",  OP_DIV,  32'd7,         32'hFFFF_FFFE, 32'h1,         32'hFFFF_FFFD, 33, 1'b0);
        run_div("divu_big",  OP_DIVU, 32'hFFFF_FFF9, 32'd2,         32'h1,         32'h7FFF_FFFC, 33, 1'b0);
        run_div("divu_by0",  OP_DIVU, 32'd100,       32'd0,         32'h0,         32'h0,         2,  1'b0);
        drive(OP_DIVU, S_NOP, 32'd100, 32'd7, 5'd3, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) begin
            want("flush_run", 5'd3, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1);
            tick();
        end
        bus.flush_i = 1'b1;
        want("flush_cyc", 5'd3, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
        tick();
        nop_idle("flush_idle");
        run_div("divu_9_3",  OP_DIVU, 32'd9,         32'd3,         32'h0,         32'h3,         33, 1'b0);
        run_div("flush_end", OP_DIVU, 32'd9,         32'd3,         32'h0,         32'h3,         33, 1'b1);
        drive(OP_DIV, S_NOP, 32'hFFFF_FFF9, 32'd2, 5'd3, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            want("rst_pre", 5'd3, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1);
            tick();
        end
        rst = 1'b1;
        want("rst_mid", 5'd0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 36; i++)
            nop_idle("rst_after");
        run_div("post_rst",  OP_DIVU, 32'd100,       32'd0,         32'h0,         32'h0,         2,  1'b0);
`else
        drive(OP_DIV, S_NOP, 32'hFFFF_FFF9, 32'd2, 5'd3, 1'b1, 1'b0);
        for (int i = 0; i < 36; i++) begin
            want("nodiv", 5'd3, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
            tick();
        end
        bus.flush_i = 1'b1;
        want("nodiv_flush", 5'd3, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
        tick();
        nop_idle("nodiv_idle");
`endif
        tick();
        if (q.size() != 0) begin
            checks++;
            $display("FAIL drain: got %0d unchecked expectations, want 0", q.size());
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
